tiger_icache_fill_ctrl: RTL

Line-refill sequencer for the Tiger instruction cache. On a miss it issues one Avalon-MM burst read for the whole line and assembles the returned beats into a line buffer. It forwards the requested word to the CPU as soon as that word arrives (early restart), then writes the completed line into the cache data array in one cycle. It also drives the word-select input of the icache word mux.

---
 rtl/tiger_icache_pkg.sv | 22 ++
 rtl/tiger_icache_line_buf.sv | 31 +++
 rtl/tiger_icache_fill_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/tiger_icache_pkg.sv
// Shared types and defaults for the Tiger instruction-cache refill logic.
package tiger_icache_pkg;

  localparam int N_DEF = 32;
  localparam int M_DEF = 8;
  localparam int S_DEF = 3;

  // Word offset within a line sits just above the 2-bit byte offset.
  localparam int OFF_LSB = 2;

  function automatic int off_msb(input int s);
    return s + 1;
  endfunction

  typedef enum logic [1:0] {
    ICF_IDLE  = 2'd0,
    ICF_REQ   = 2'd1,
    ICF_FILL  = 2'd2,
    ICF_WRITE = 2'd3
  } icf_state_t;

endpackage

// File: rtl/tiger_icache_line_buf.sv
// M x N register file that assembles refill beats into one flat cache line.
module tiger_icache_line_buf
  import tiger_icache_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int S = S_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           we,
  input  logic [S-1:0]   idx,
  input  logic [N-1:0]   wdata,
  output logic [M*N-1:0] line
);

  logic [N-1:0] mem [M];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < M; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  for (genvar k = 0; k < M; k++) begin : g_flat
    assign line[N*k +: N] = mem[k];
  end

endmodule

// File: rtl/tiger_icache_fill_ctrl.sv
// Icache line-refill sequencer: one Avalon burst per miss, early restart of
// the requested word, single-cycle write of the assembled line.
module tiger_icache_fill_ctrl
  import tiger_icache_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int M      = M_DEF,
  parameter int S      = S_DEF,
  parameter int ADDR_W = 32,
  parameter int W      = M * N
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic [ADDR_W-1:0]     cpu_addr,
  output logic                  fill_busy,
  output logic [N-1:0]          cpu_rdata,
  output logic                  cpu_rvalid,
  output logic [S-1:0]          word_sel,
  output logic                  mem_read,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [S:0]            mem_burstcount,
  input  logic                  mem_waitrequest,
  input  logic [N-1:0]          mem_readdata,
  input  logic                  mem_readdatavalid,
  output logic                  line_we,
  output logic [ADDR_W-S-3:0]   line_addr,
  output logic [W-1:0]          line_wdata
);

  localparam logic [S:0] LAST_BEAT = (S+1)'(M - 1);

  icf_state_t state, state_nx;
  logic [S:0] beat_cnt;
  logic       accept;
  logic       beat_take;
  logic       unused_byte_off;

  assign unused_byte_off = ^cpu_addr[OFF_LSB-1:0];

  assign accept    = (state == ICF_IDLE) && cpu_req;
  assign beat_take = (state == ICF_FILL) && mem_readdatavalid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ICF_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ICF_IDLE:  if (cpu_req) state_nx = ICF_REQ;
      ICF_REQ:   if (!mem_waitrequest) state_nx = ICF_FILL;
      ICF_FILL:  if (mem_readdatavalid && beat_cnt == LAST_BEAT) state_nx = ICF_WRITE;
      ICF_WRITE: state_nx = ICF_IDLE;
      default:   state_nx = ICF_IDLE;
    endcase
  end

  // Decodes of the state register only, so no input reaches an output combinationally.
  assign fill_busy      = (state != ICF_IDLE);
  assign mem_read       = (state == ICF_REQ);
  assign line_we        = (state == ICF_WRITE);
  assign mem_burstcount = (S+1)'(M);

  // The latched request address is kept only as the two fields actually used.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_sel    <= '0;
      mem_address <= '0;
      line_addr   <= '0;
      beat_cnt    <= '0;
      cpu_rdata   <= '0;
      cpu_rvalid  <= 1'b0;
    end else begin
      cpu_rvalid <= 1'b0;
      if (accept) begin
        word_sel    <= cpu_addr[OFF_LSB +: S];
        mem_address <= {cpu_addr[ADDR_W-1:S+2], {(S+2){1'b0}}};
        line_addr   <= cpu_addr[ADDR_W-1:S+2];
      end
      if (state == ICF_REQ && !mem_waitrequest) beat_cnt <= '0;
      if (beat_take) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (beat_cnt == {1'b0, word_sel}) begin
          cpu_rdata  <= mem_readdata;
          cpu_rvalid <= 1'b1;
        end
      end
    end
  end

  tiger_icache_line_buf #(
    .N(N),
    .M(M),
    .S(S)
  ) u_line_buf (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (beat_take),
    .idx    (beat_cnt[S-1:0]),
    .wdata  (mem_readdata),
    .line   (line_wdata)
  );

  a_no_beat_in_req: assert property (@(posedge clk) disable iff (!reset_n)
    !(state == ICF_REQ && mem_readdatavalid));

endmodule
